// File: rtl/mux_key_table.sv
// Runtime-programmable key->data lookup table with a valid/ready request port and a
// single registered response slot; lowest-index valid match wins, a miss returns the default.
module mux_key_table #(
  parameter int NR_KEY      = 4,
  parameter int KEY_LEN     = 4,
  parameter int DATA_LEN    = 32,
  parameter bit HAS_DEFAULT = 1'b1,
  localparam int IDX_W      = (NR_KEY <= 2) ? 1 : $clog2(NR_KEY),
  localparam int CNT_W      = $clog2(NR_KEY + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [KEY_LEN-1:0]  wr_key,
  input  logic [DATA_LEN-1:0] wr_data,
  input  logic                inv_en,
  input  logic [IDX_W-1:0]    inv_idx,
  input  logic                clr_all,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [KEY_LEN-1:0]  req_key,
  input  logic [DATA_LEN-1:0] default_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_LEN-1:0] rsp_data,
  output logic                rsp_hit,
  output logic [IDX_W-1:0]    rsp_idx,
  output logic                rsp_multi,
  output logic [CNT_W-1:0]    count
);

  logic [NR_KEY-1:0]   valid_q;
  logic [NR_KEY-1:0]   valid_d;
  logic [KEY_LEN-1:0]  key_q  [NR_KEY];
  logic [DATA_LEN-1:0] data_q [NR_KEY];
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;

  logic                look_hit;
  logic                look_multi;
  logic [IDX_W-1:0]    look_idx;
  logic [DATA_LEN-1:0] look_data;

  // Scanning from the top down lets the lowest matching index be the last one assigned.
  always_comb begin
    look_hit   = 1'b0;
    look_multi = 1'b0;
    look_idx   = '0;
    look_data  = HAS_DEFAULT ? default_out : '0;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (valid_q[i] && key_q[i] == req_key) begin
        if (look_hit) look_multi = 1'b1;
        look_hit  = 1'b1;
        look_idx  = IDX_W'(i);
        look_data = data_q[i];
      end
    end
  end

  // Out-of-range indices simply never equal any entry number, so they fall through.
  always_comb begin
    valid_d = valid_q;
    count_d = '0;
    if (clr_all) begin
      valid_d = '0;
    end else begin
      for (int i = 0; i < NR_KEY; i++) begin
        if (inv_en && inv_idx == IDX_W'(i)) valid_d[i] = 1'b0;
        if (wr_en && wr_idx == IDX_W'(i))   valid_d[i] = 1'b1;
      end
    end
    for (int i = 0; i < NR_KEY; i++) begin
      count_d = count_d + CNT_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      count_q <= '0;
      for (int i = 0; i < NR_KEY; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      count_q <= count_d;
      for (int i = 0; i < NR_KEY; i++) begin
        if (wr_en && !clr_all && wr_idx == IDX_W'(i)) begin
          key_q[i]  <= wr_key;
          data_q[i] <= wr_data;
        end
      end
    end
  end

  assign req_ready = !rsp_valid || rsp_ready;

  // The response slot only moves when it is empty or being drained this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_hit   <= 1'b0;
      rsp_idx   <= '0;
      rsp_multi <= 1'b0;
    end else if (req_ready) begin
      rsp_valid <= req_valid;
      if (req_valid) begin
        rsp_data  <= look_data;
        rsp_hit   <= look_hit;
        rsp_idx   <= look_idx;
        rsp_multi <= look_multi;
      end
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_mux_key_table.sv
// Bench for mux_key_table: two configurations (4 entries with default, 3 entries without)
// driven in parallel and checked against a rule-level model plus hand-computed literals.
module tb_mux_key_table;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [1:0]  wr_idx;
  logic [3:0]  wr_key;
  logic [31:0] wr_data;
  logic        inv_en;
  logic [1:0]  inv_idx;
  logic        clr_all;
  logic        req_valid;
  logic [3:0]  req_key;
  logic [31:0] default_out;
  logic        rsp_ready;

  logic        a_req_ready, a_rsp_valid, a_rsp_hit, a_rsp_multi;
  logic [31:0] a_rsp_data;
  logic [1:0]  a_rsp_idx;
  logic [2:0]  a_count;
  logic        b_req_ready, b_rsp_valid, b_rsp_hit, b_rsp_multi;
  logic [31:0] b_rsp_data;
  logic [1:0]  b_rsp_idx;
  logic [1:0]  b_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mux_key_table #(.NR_KEY(4), .KEY_LEN(4), .DATA_LEN(32), .HAS_DEFAULT(1'b1)) dut_a (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key), .wr_data(wr_data),
    .inv_en(inv_en), .inv_idx(inv_idx), .clr_all(clr_all), .req_valid(req_valid),
    .req_ready(a_req_ready), .req_key(req_key), .default_out(default_out),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data), .rsp_hit(a_rsp_hit),
    .rsp_idx(a_rsp_idx), .rsp_multi(a_rsp_multi), .count(a_count)
  );

  mux_key_table #(.NR_KEY(3), .KEY_LEN(4), .DATA_LEN(32), .HAS_DEFAULT(1'b0)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key), .wr_data(wr_data),
    .inv_en(inv_en), .inv_idx(inv_idx), .clr_all(clr_all), .req_valid(req_valid),
    .req_ready(b_req_ready), .req_key(req_key), .default_out(default_out),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data), .rsp_hit(b_rsp_hit),
    .rsp_idx(b_rsp_idx), .rsp_multi(b_rsp_multi), .count(b_count)
  );

  // Model state, one copy per configuration: [0] = 4 entries with default, [1] = 3 entries without.
  bit          m_valid [2][4];
  logic [3:0]  m_key   [2][4];
  logic [31:0] m_data  [2][4];
  bit          e_valid [2];
  logic [31:0] e_data  [2];
  bit          e_hit   [2];
  int          e_idx   [2];
  bit          e_multi [2];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  function automatic int model_count(input int m);
    int n = 0;
    for (int i = 0; i < 4; i++) if (m_valid[m][i]) n++;
    return n;
  endfunction

  // Rule-level model: first match in ascending order, tables updated after the lookup.
  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      int nr;
      nr = (m == 0) ? 4 : 3;
      if (rst) begin
        e_valid[m] = 1'b0; e_data[m] = 0; e_hit[m] = 1'b0; e_idx[m] = 0; e_multi[m] = 1'b0;
        for (int i = 0; i < 4; i++) begin
          m_valid[m][i] = 1'b0; m_key[m][i] = 0; m_data[m][i] = 0;
        end
      end else begin
        if (!e_valid[m] || rsp_ready) begin
          if (req_valid) begin
            e_valid[m] = 1'b1;
            e_hit[m]   = 1'b0;
            e_multi[m] = 1'b0;
            e_idx[m]   = 0;
            e_data[m]  = (m == 0) ? default_out : 32'h0;
            for (int i = 0; i < nr; i++) begin
              if (m_valid[m][i] && m_key[m][i] == req_key) begin
                if (!e_hit[m]) begin
                  e_hit[m] = 1'b1; e_idx[m] = i; e_data[m] = m_data[m][i];
                end else begin
                  e_multi[m] = 1'b1;
                end
              end
            end
          end else begin
            e_valid[m] = 1'b0;
          end
        end
        if (clr_all) begin
          for (int i = 0; i < 4; i++) m_valid[m][i] = 1'b0;
        end else begin
          if (inv_en && int'(inv_idx) < nr && !(wr_en && wr_idx == inv_idx))
            m_valid[m][inv_idx] = 1'b0;
          if (wr_en && int'(wr_idx) < nr) begin
            m_valid[m][wr_idx] = 1'b1;
            m_key[m][wr_idx]   = wr_key;
            m_data[m][wr_idx]  = wr_data;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("a.rsp_valid", 32'(a_rsp_valid), 32'(e_valid[0]));
      checkOutput("a.req_ready", 32'(a_req_ready), 32'(!e_valid[0] || rsp_ready));
      checkOutput("a.count", 32'(a_count), 32'(model_count(0)));
      checkOutput("b.rsp_valid", 32'(b_rsp_valid), 32'(e_valid[1]));
      checkOutput("b.req_ready", 32'(b_req_ready), 32'(!e_valid[1] || rsp_ready));
      checkOutput("b.count", 32'(b_count), 32'(model_count(1)));
      if (e_valid[0]) begin
        checkOutput("a.rsp_data", a_rsp_data, e_data[0]);
        checkOutput("a.rsp_hit", 32'(a_rsp_hit), 32'(e_hit[0]));
        checkOutput("a.rsp_idx", 32'(a_rsp_idx), 32'(e_idx[0]));
        checkOutput("a.rsp_multi", 32'(a_rsp_multi), 32'(e_multi[0]));
      end
      if (e_valid[1]) begin
        checkOutput("b.rsp_data", b_rsp_data, e_data[1]);
        checkOutput("b.rsp_hit", 32'(b_rsp_hit), 32'(e_hit[1]));
        checkOutput("b.rsp_idx", 32'(b_rsp_idx), 32'(e_idx[1]));
        checkOutput("b.rsp_multi", 32'(b_rsp_multi), 32'(e_multi[1]));
      end
    end
  end

  task automatic applyStimulus(
    input logic w, input logic [1:0] wi, input logic [3:0] wk, input logic [31:0] wd,
    input logic iv, input logic [1:0] ii, input logic c,
    input logic rv, input logic [3:0] rk, input logic [31:0] d, input logic rr);
    wr_en = w; wr_idx = wi; wr_key = wk; wr_data = wd;
    inv_en = iv; inv_idx = ii; clr_all = c;
    req_valid = rv; req_key = rk; default_out = d; rsp_ready = rr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk_en = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    checkOutput("reset a.rsp_valid", 32'(a_rsp_valid), 0);
    checkOutput("reset a.req_ready", 32'(a_req_ready), 1);
    checkOutput("reset a.count", 32'(a_count), 0);

    // T1: miss on an empty table
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4'd3, 32'hDEAD, 1);
    checkOutput("T1 a.rsp_valid", 32'(a_rsp_valid), 1);
    checkOutput("T1 a.rsp_data", a_rsp_data, 32'hDEAD);
    checkOutput("T1 a.rsp_hit", 32'(a_rsp_hit), 0);
    checkOutput("T1 b.rsp_data", b_rsp_data, 32'h0);

    // T2: duplicate keys, lowest index wins; idx3 out of range for the 3-entry table
    applyStimulus(1, 2'd1, 4'd5, 32'h11, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(1, 2'd3, 4'd5, 32'h33, 0, 0, 0, 0, 0, 0, 1);
    checkOutput("T6 b.count after idx3 write", 32'(b_count), 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4'd5, 32'hDEAD, 1);
    checkOutput("T2 a.rsp_data", a_rsp_data, 32'h11);
    checkOutput("T2 a.rsp_idx", 32'(a_rsp_idx), 1);
    checkOutput("T2 a.rsp_multi", 32'(a_rsp_multi), 1);
    checkOutput("T2 a.count", 32'(a_count), 2);
    checkOutput("T2 b.rsp_multi", 32'(b_rsp_multi), 0);

    // T3: read-before-write
    applyStimulus(1, 2'd0, 4'd7, 32'h77, 0, 0, 0, 1, 4'd7, 32'hBEEF, 1);
    checkOutput("T3 a.rsp_data same cycle", a_rsp_data, 32'hBEEF);
    checkOutput("T3 a.rsp_hit same cycle", 32'(a_rsp_hit), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4'd7, 32'hBEEF, 1);
    checkOutput("T3 a.rsp_data next", a_rsp_data, 32'h77);
    checkOutput("T3 a.count", 32'(a_count), 3);

    // T4: backpressure for three cycles, then a burst
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4'd5, 32'hBEEF, 0);
      checkOutput("T4 a.req_ready held", 32'(a_req_ready), 0);
      checkOutput("T4 a.rsp_data held", a_rsp_data, 32'h77);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4'd5, 32'hBEEF, 1);
    checkOutput("T4 a.rsp_data burst0", a_rsp_data, 32'h11);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4'd7, 32'hBEEF, 1);
    checkOutput("T4 a.rsp_data burst1", a_rsp_data, 32'h77);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4'd3, 32'hCAFE, 1);
    checkOutput("T4 a.rsp_data burst2", a_rsp_data, 32'hCAFE);

    // T5: write beats invalidate at the same index
    applyStimulus(1, 2'd2, 4'd9, 32'h99, 1, 2'd2, 0, 0, 0, 0, 1);
    checkOutput("T5 a.count", 32'(a_count), 4);
    checkOutput("T5 b.count", 32'(b_count), 3);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4'd9, 32'h0, 1);
    checkOutput("T5 a.rsp_idx", 32'(a_rsp_idx), 2);
    checkOutput("T5 a.rsp_data", a_rsp_data, 32'h99);
    // different indices both apply; rewrite keeps the count; invalid re-invalidate is a no-op
    applyStimulus(1, 2'd1, 4'hA, 32'hAA, 1, 2'd0, 0, 0, 0, 0, 1);
    checkOutput("T5 a.count after wr+inv", 32'(a_count), 3);
    applyStimulus(1, 2'd1, 4'hB, 32'hBB, 1, 2'd0, 0, 1, 4'hA, 32'h5A5A, 1);
    checkOutput("T5 a.count rewrite", 32'(a_count), 3);
    checkOutput("T5 a.rsp_data old key", a_rsp_data, 32'hAA);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4'hB, 32'h5A5A, 1);
    checkOutput("T5 a.rsp_data new key", a_rsp_data, 32'hBB);
    applyStimulus(1, 2'd0, 4'd1, 32'h1, 0, 0, 1, 0, 0, 0, 1);
    checkOutput("T5 a.count after clr", 32'(a_count), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4'd1, 32'h0F0F, 1);
    checkOutput("T5 a.rsp_hit after clr", 32'(a_rsp_hit), 0);
    checkOutput("T6 b.rsp_data miss", b_rsp_data, 32'h0);

    // Reset while a response is stalled drops it
    applyStimulus(1, 2'd3, 4'd4, 32'h44, 0, 0, 0, 1, 4'd4, 32'h0, 0);
    rst = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4'd4, 32'h0, 0);
    rst = 1'b0;
    checkOutput("reset drop a.rsp_valid", 32'(a_rsp_valid), 0);
    checkOutput("reset drop a.count", 32'(a_count), 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
